core_sys_char_blitter: RTL and testbench
========================================

Name: core_sys_char_blitter

Overview:
Bulk-operation engine for the 8192x8 dual-port character memory, attached to its second port (s2). The CPU starts clear-screen, scroll-up and fill-row operations through a small Avalon-MM CSR slave. The engine then sequences the memory accesses itself, freeing the CPU from byte-by-byte loops over port s1. Completion is reported by a status bit and an optional interrupt.

Parameters:
- COLS, 80, characters per text row.
- ROWS, 60, text rows; COLS*ROWS must be <= 2**ADDR_W (elaboration-time check).
- ADDR_W, 13, character-memory address width.
- DATA_W, 8, character code width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  2  CSR word offset
- avs_chipselect  in  1  CSR select
- avs_read  in  1  CSR read strobe
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_readdata  out  32  CSR read data, read latency 1
- irq  out  1  level interrupt = done & irq_en
- mem_address  out  ADDR_W  port-2 address
- mem_chipselect  out  1  port-2 select
- mem_write  out  1  port-2 write enable
- mem_writedata  out  DATA_W  port-2 write data
- mem_clken  out  1  port-2 clock enable; 1 while busy, 0 in IDLE
- mem_readdata  in  DATA_W  port-2 read data, valid 1 cycle after address

Behaviour:
- Reset values: all outputs 0; fill_char 0x20; irq_en, done and err all 0; FSM in IDLE.
- CSR map:
  - Offset 0 CMD (write-only): [1:0] op (0 NOP, 1 CLEAR, 2 SCROLL, 3 FILL_ROW); [13:8] row.
  - Offset 1 FILL (R/W): [7:0] fill_char.
  - Offset 2 STATUS: read [0] busy, [1] done, [2] err; write 1 to [1] or [2] clears that bit.
  - Offset 3 IRQ_EN (R/W): [0].
- CSR readdata registered one cycle after avs_read & avs_chipselect. Unused bits read 0. CMD reads 0.
- Command acceptance:
  - A CMD write in IDLE with op != 0 is accepted.
  - Acceptance clears done and sets busy at the same edge.
  - The first memory access occurs in the next cycle.
- Rejected commands set err and leave state unchanged:
  - CMD write while busy.
  - FILL_ROW with row >= ROWS.
- NOP: no effect.
- FILL and IRQ_EN writes while busy take effect immediately. fill_char is sampled per write cycle, so software must not change it mid-operation.
- FSM states: IDLE, FILL, COPY_RD, COPY_WR.
  - CLEAR: FILL over addresses 0..COLS*ROWS-1, one write per cycle, COLS*ROWS cycles.
  - FILL_ROW r: FILL over row*COLS..row*COLS+COLS-1, COLS cycles.
  - SCROLL, copy phase: for a = 0..(ROWS-1)*COLS-1, alternate COPY_RD (address a+COLS, write 0) and COPY_WR (address a, write 1, data = mem_readdata). That is 2 cycles per byte.
  - SCROLL, fill phase: FILL over the last row, (ROWS-1)*COLS..ROWS*COLS-1.
  - Total SCROLL time: 2*(ROWS-1)*COLS + COLS cycles.
- Completion: on the edge after the final write, busy goes to 0, done to 1, and the FSM returns to IDLE.
- mem_chipselect equals busy. mem_write is asserted only in FILL and COPY_WR.
- Address counter width ADDR_W. The terminal compare uses an exact end address; no wrap-around is ever reached.
- Reset mid-operation aborts immediately and returns all outputs to reset values. Memory contents are left partially updated, which is acceptable.
- Simultaneous STATUS clear-write and completion edge: the set wins, so done = 1.

Decomposition:
- Shared package core_sys_char_pkg holds:
  - opcode constants OP_NOP, OP_CLEAR, OP_SCROLL, OP_FILL_ROW;
  - CSR offsets CSR_CMD, CSR_FILL, CSR_STATUS, CSR_IRQ_EN;
  - STATUS bit indices;
  - the FSM state encoding.
- No sub-module is natural. The CSR block, FSM and address counter form a single module.

Test Plan:
- Reset, then read STATUS -> 0x0; read FILL -> 0x20; irq = 0; mem_chipselect = 0.
- Write FILL = 0x41, write CMD = 0x1 -> 4800 consecutive writes of 0x41 to addresses 0..4799. busy = 1 throughout; done = 1 on the cycle after the last write. Every address is 0x41 via a port-1 model.
- Preload row k with value k (k = 0..59), FILL = 0x2E, CMD = 0x2 -> after 9520 cycles, row k holds k+1 for k < 59 and row 59 holds 0x2E. No write occurs before its source read.
- CMD = 0x3 with row = 5 (writedata 0x0503) -> addresses 400..479 written; 399 and 480 untouched. CMD with row = 60 -> err = 1, busy stays 0, no memory access.
- CMD written while busy -> err = 1 and the running operation finishes unchanged. Writing 0x6 to STATUS clears done and err.
- IRQ_EN = 1, then CLEAR -> irq rises with done. Assert reset mid-CLEAR -> busy = 0, irq = 0 and mem_write = 0 immediately, with no further memory accesses.

Source files
------------

// File: rtl/core_sys_char_pkg.sv
// Shared definitions for the character-memory blitter: opcodes, CSR map,
// STATUS bit positions and the FSM state encoding.
package core_sys_char_pkg;

    localparam logic [1:0] OP_NOP      = 2'd0;
    localparam logic [1:0] OP_CLEAR    = 2'd1;
    localparam logic [1:0] OP_SCROLL   = 2'd2;
    localparam logic [1:0] OP_FILL_ROW = 2'd3;

    localparam logic [1:0] CSR_CMD    = 2'd0;
    localparam logic [1:0] CSR_FILL   = 2'd1;
    localparam logic [1:0] CSR_STATUS = 2'd2;
    localparam logic [1:0] CSR_IRQ_EN = 2'd3;

    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;
    localparam int unsigned STATUS_ERR  = 2;

    localparam int unsigned CMD_ROW_LSB = 8;
    localparam int unsigned CMD_ROW_W   = 6;

    localparam logic [7:0] FILL_CHAR_RESET = 8'h20;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StCopyRd,
        StCopyWr
    } blit_state_e;

endpackage

// File: rtl/core_sys_char_blitter.sv
// Bulk clear / scroll-up / fill-row engine on port 2 of the character memory,
// controlled through a four-word Avalon-MM CSR slave.
module core_sys_char_blitter
    import core_sys_char_pkg::*;
#(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 60,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int unsigned CELLS = COLS * ROWS;

    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] COPY_END_A = ADDR_W'((ROWS - 1) * COLS - 1);

    if (64'(CELLS) > (64'd1 << ADDR_W)) begin : g_size_check
        $error("COLS*ROWS does not fit in the character memory address space");
    end

    blit_state_e         state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   end_addr;
    logic                done;
    logic                err;
    logic                irq_en;
    logic [DATA_W-1:0]   fill_char;
    logic [31:0]         readdata;

    logic                busy;
    logic                csr_wr;
    logic                cmd_wr;
    logic [1:0]          cmd_op;
    logic [CMD_ROW_W-1:0] cmd_row;
    logic                row_bad;
    logic [ADDR_W-1:0]   row_start;
    logic                accept;
    logic                reject;
    logic [31:0]         csr_rdata;
    logic                unused_wdata;

    assign busy      = (state != StIdle);
    assign csr_wr    = avs_chipselect & avs_write;
    assign cmd_wr    = csr_wr && (avs_address == CSR_CMD);
    assign cmd_op    = avs_writedata[1:0];
    assign cmd_row   = avs_writedata[CMD_ROW_LSB +: CMD_ROW_W];
    assign row_bad   = (32'(cmd_row) >= ROWS);
    assign row_start = ADDR_W'(32'(cmd_row) * COLS);

    // Any CMD write while busy is an error, including NOP.
    assign reject = cmd_wr && (busy || (cmd_op == OP_FILL_ROW && row_bad));
    assign accept = cmd_wr && !reject && (cmd_op != OP_NOP);

    assign unused_wdata = ^avs_writedata[31:CMD_ROW_LSB + CMD_ROW_W];

    always_comb begin
        csr_rdata = '0;
        case (avs_address)
            CSR_FILL:   csr_rdata[DATA_W-1:0] = fill_char;
            CSR_STATUS: begin
                csr_rdata[STATUS_BUSY] = busy;
                csr_rdata[STATUS_DONE] = done;
                csr_rdata[STATUS_ERR]  = err;
            end
            CSR_IRQ_EN: csr_rdata[0] = irq_en;
            default:    csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            addr      <= '0;
            end_addr  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            irq_en    <= 1'b0;
            fill_char <= DATA_W'(FILL_CHAR_RESET);
            readdata  <= '0;
        end else begin
            if (avs_chipselect && avs_read) begin
                readdata <= csr_rdata;
            end
            if (csr_wr && avs_address == CSR_FILL) begin
                fill_char <= avs_writedata[DATA_W-1:0];
            end
            if (csr_wr && avs_address == CSR_IRQ_EN) begin
                irq_en <= avs_writedata[0];
            end
            if (csr_wr && avs_address == CSR_STATUS) begin
                if (avs_writedata[STATUS_DONE]) done <= 1'b0;
                if (avs_writedata[STATUS_ERR])  err  <= 1'b0;
            end
            if (reject) begin
                err <= 1'b1;
            end

            // Later assignments to done override the STATUS clear above.
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        done <= 1'b0;
                        case (cmd_op)
                            OP_CLEAR: begin
                                state    <= StFill;
                                addr     <= '0;
                                end_addr <= LAST_A;
                            end
                            OP_SCROLL: begin
                                state    <= (ROWS > 1) ? StCopyRd : StFill;
                                addr     <= '0;
                                end_addr <= LAST_A;
                            end
                            OP_FILL_ROW: begin
                                state    <= StFill;
                                addr     <= row_start;
                                end_addr <= row_start + COLS_A - 1'b1;
                            end
                            default: state <= StIdle;
                        endcase
                    end
                end
                StFill: begin
                    if (addr == end_addr) begin
                        state <= StIdle;
                        addr  <= '0;
                        done  <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                StCopyRd: begin
                    state <= StCopyWr;
                end
                StCopyWr: begin
                    // The copy ends one address before the last row, which the fill phase owns.
                    addr  <= addr + 1'b1;
                    state <= (addr == COPY_END_A) ? StFill : StCopyRd;
                end
            endcase
        end
    end

    assign avs_readdata   = readdata;
    assign irq            = done & irq_en;
    assign mem_chipselect = busy;
    assign mem_clken      = busy;
    assign mem_write      = (state == StFill) || (state == StCopyWr);

    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        unique case (state)
            StIdle: begin
                mem_address   = '0;
                mem_writedata = '0;
            end
            StFill: begin
                mem_address   = addr;
                mem_writedata = fill_char;
            end
            StCopyRd: begin
                mem_address = addr + COLS_A;
            end
            StCopyWr: begin
                mem_address   = addr;
                mem_writedata = mem_readdata;
            end
        endcase
    end

endmodule

// File: tb/tb_core_sys_char_blitter.sv
// Randomized self-checking bench: a byte-array memory model on port 2 and a
// row/column reference model of each bulk operation.
module tb_core_sys_char_blitter;
    import core_sys_char_pkg::*;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 60;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WAIT_LIMIT = 12000;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        avs_address;
    logic              avs_chipselect;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              irq;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic [7:0] mem     [DEPTH];
    logic [7:0] pre_img [DEPTH];
    logic [7:0] model   [DEPTH];
    logic       load_req;
    int unsigned busy_cycles = 0;
    int unsigned write_count = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    core_sys_char_blitter #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .irq            (irq),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // Dual-port memory as seen from port 2 (read-before-write), plus activity counters.
    always @(posedge clk) begin
        if (load_req) begin
            mem <= pre_img;
        end else if (mem_chipselect && mem_clken && mem_write) begin
            mem[mem_address] <= mem_writedata;
        end
        mem_readdata <= mem[mem_address];
        if (mem_chipselect) busy_cycles <= busy_cycles + 1;
        if (mem_chipselect && mem_write) write_count <= write_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address    = a;
        avs_writedata  = d;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        @(negedge clk);
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address    = a;
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        @(negedge clk);
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        d = avs_readdata;
    endtask

    // rows_pattern: row k of the screen holds the value k.
    task automatic preload(input bit rows_pattern);
        for (int i = 0; i < int'(DEPTH); i++) begin
            pre_img[i] = 8'($urandom);
            if (rows_pattern && i < int'(CELLS)) pre_img[i] = 8'(i / COLS);
            model[i] = pre_img[i];
        end
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic model_fill_row(input int r, input logic [7:0] c);
        for (int col = 0; col < int'(COLS); col++) model[r * COLS + col] = c;
    endtask

    task automatic model_apply(input int op, input int row, input logic [7:0] c);
        case (op)
            1: for (int r = 0; r < int'(ROWS); r++) model_fill_row(r, c);
            2: begin
                for (int r = 0; r < int'(ROWS) - 1; r++)
                    for (int col = 0; col < int'(COLS); col++)
                        model[r * COLS + col] = model[(r + 1) * COLS + col];
                model_fill_row(ROWS - 1, c);
            end
            3: model_fill_row(row, c);
            default: ;
        endcase
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (bad != 0) $display("  first differing address %0d", first);
        check_eq({tag, "_badbytes"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (mem_chipselect === 1'b1 && n < int'(WAIT_LIMIT)) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_finished"}, 32'(n < int'(WAIT_LIMIT)), 32'd1);
    endtask

    task automatic run_op(input string tag, input int op, input int row, input logic [7:0] c);
        int unsigned c0, w0, exp_cyc, exp_wr;
        logic [31:0] d;
        bit ok;
        ok = !(op == 3 && row >= int'(ROWS));
        case (op)
            1:       begin exp_cyc = CELLS;                          exp_wr = CELLS; end
            2:       begin exp_cyc = 2 * (ROWS - 1) * COLS + COLS;   exp_wr = CELLS; end
            default: begin exp_cyc = COLS;                           exp_wr = COLS;  end
        endcase
        if (!ok) begin
            exp_cyc = 0;
            exp_wr  = 0;
        end
        csr_write(CSR_FILL, 32'(c));
        csr_write(CSR_STATUS, 32'h6);
        c0 = busy_cycles;
        w0 = write_count;
        csr_write(CSR_CMD, 32'((row << 8) | op));
        wait_idle(tag);
        if (ok) model_apply(op, row, c);
        check_eq({tag, "_cycles"}, busy_cycles - c0, exp_cyc);
        check_eq({tag, "_writes"}, write_count - w0, exp_wr);
        csr_read(CSR_STATUS, d);
        check_eq({tag, "_status"}, d, ok ? 32'h2 : 32'h4);
        check_mem(tag);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  c;
        int unsigned w0;
        reset          = 1'b1;
        load_req       = 1'b0;
        avs_address    = '0;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        csr_read(CSR_STATUS, d);
        check_eq("rst_status", d, 32'h0);
        csr_read(CSR_FILL, d);
        check_eq("rst_fill", d, 32'h20);
        csr_read(CSR_IRQ_EN, d);
        check_eq("rst_irq_en", d, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_mem_cs", 32'(mem_chipselect), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_write), 32'd0);

        preload(1'b0);
        run_op("clear41", 1, 0, 8'h41);

        preload(1'b1);
        run_op("scroll", 2, 0, 8'h2E);

        preload(1'b0);
        run_op("row5", 3, 5, 8'($urandom));
        run_op("row60", 3, 60, 8'($urandom));
        run_op("row59", 3, 59, 8'($urandom));

        // A second command while busy is refused and the running CLEAR completes.
        preload(1'b0);
        csr_write(CSR_FILL, 32'h5A);
        csr_write(CSR_STATUS, 32'h6);
        csr_write(CSR_CMD, 32'h1);
        repeat (10) @(negedge clk);
        csr_write(CSR_CMD, 32'h0503);
        csr_read(CSR_STATUS, d);
        check_eq("busy_status", d, 32'h5);
        wait_idle("busy");
        model_apply(1, 0, 8'h5A);
        check_mem("busy");
        csr_read(CSR_STATUS, d);
        check_eq("busy_done_err", d, 32'h6);
        csr_write(CSR_STATUS, 32'h6);
        csr_read(CSR_STATUS, d);
        check_eq("status_cleared", d, 32'h0);

        csr_write(CSR_IRQ_EN, 32'h1);
        csr_read(CSR_IRQ_EN, d);
        check_eq("irq_en_rd", d, 32'h1);
        preload(1'b0);
        run_op("irq_clear", 1, 0, 8'($urandom));
        check_eq("irq_high", 32'(irq), 32'd1);
        csr_write(CSR_STATUS, 32'h2);
        check_eq("irq_low", 32'(irq), 32'd0);

        // Reset in the middle of a CLEAR.
        csr_write(CSR_CMD, 32'h1);
        repeat (100) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_cs", 32'(mem_chipselect), 32'd0);
        check_eq("abort_wr", 32'(mem_write), 32'd0);
        check_eq("abort_clken", 32'(mem_clken), 32'd0);
        check_eq("abort_irq", 32'(irq), 32'd0);
        w0 = write_count;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("abort_nowrites", write_count - w0, 32'd0);
        csr_read(CSR_STATUS, d);
        check_eq("abort_status", d, 32'h0);
        csr_read(CSR_FILL, d);
        check_eq("abort_fill", d, 32'h20);
        csr_read(CSR_IRQ_EN, d);
        check_eq("abort_irq_en", d, 32'h0);

        for (int it = 0; it < 3; it++) begin
            int op;
            int row;
            op  = int'($urandom_range(1, 3));
            row = int'($urandom_range(0, 63));
            c   = 8'($urandom);
            preload(1'b0);
            run_op($sformatf("rand%0d_op%0d_r%0d", it, op, row), op, row, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
